// File: rtl/mips_core_pkg.sv
// Shared types and defaults for the Mini-MIPS fetch path.
package mips_core_pkg;

    localparam int                    PC_W_DEF     = 32;
    localparam logic [PC_W_DEF-1:0]   RESET_PC_DEF = '0;
    localparam logic [31:0]           INST_NOP     = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]         inst;
        logic [PC_W_DEF-1:0] pc;
    } fetch_entry_t;

    // RUN: issuing, STALL: credit exhausted, FLUSH: cycle after a redirect
    typedef enum logic [1:0] {
        FETCH_RUN,
        FETCH_STALL,
        FETCH_FLUSH
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect input and decode handshake.
interface instruction_fetch_unit_if #(
    parameter int PC_W = 32
) ();

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [PC_W-1:0] inst_pc;
    logic [PC_W-1:0] inst_pc4;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst, inst_pc, inst_pc4,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst, inst_pc, inst_pc4,
        output inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with single-cycle flush; DEPTH must be a power of 2.
module fetch_fifo
    import mips_core_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Flush beats both push and pop in the same cycle.
    assign do_push = push_i & !flush_i;
    assign do_pop  = pop_i & !empty_o & !flush_i;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap mod DEPTH naturally because DEPTH is a power of 2.
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; entries are only visible through count/empty, which are.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Mini-MIPS instruction fetch: PC, credit-based imem issue, output FIFO, redirect flush.
// Optional FETCH_STATS_EN adds saturating fetched/flushed counters.
module instruction_fetch_unit
    import mips_core_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF),
    parameter int              BUF_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    instruction_fetch_unit_if.master   bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]                stat_fetched_o,
    output logic [31:0]                stat_flushed_o
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  issued_pc_q;
    logic             inflight_q;
    logic             issue, pop, push, flush, drop;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   credit_used;
    logic             full, empty;
    fetch_entry_t     head, push_entry;

    assign flush = bus.redirect_valid;
    assign pop   = bus.inst_valid & bus.inst_ready;
    assign drop  = (state_q == FETCH_FLUSH);
    assign push  = inflight_q & !drop;

    // Entries held plus the one in flight, minus the one leaving this cycle.
    assign credit_used = {1'b0, count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        issue   = 1'b0;
        if (flush) begin
            state_d = FETCH_FLUSH;
            pc_d    = bus.redirect_pc & ~PC_W'(3);
        end else if (credit_used < (CNT_W+1)'(BUF_DEPTH)) begin
            state_d = FETCH_RUN;
            issue   = 1'b1;
            pc_d    = pc_q + PC_W'(4);
        end else begin
            state_d = FETCH_STALL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH_RUN;
            pc_q        <= RESET_PC;
            issued_pc_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) issued_pc_q <= pc_q;
        end
    end

    assign bus.imem_req  = issue & !rst;
    assign bus.imem_addr = bus.imem_req ? pc_q : '0;

    always_comb begin
        push_entry      = '0;
        push_entry.inst = bus.imem_rdata;
        push_entry.pc   = PC_W_DEF'(issued_pc_q);
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    // Outputs read as zero whenever the FIFO is empty, including during reset.
    assign bus.inst_valid = !empty;
    assign bus.inst       = empty ? INST_NOP : head.inst;
    assign bus.inst_pc    = empty ? '0 : head.pc[PC_W-1:0];
    assign bus.inst_pc4   = empty ? '0 : head.pc[PC_W-1:0] + PC_W'(4);

    overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && full && !flush && !pop));

`ifdef FETCH_STATS_EN
    logic [31:0]    stat_fetched_q, stat_flushed_q;
    logic [CNT_W:0] flushed_inc;
    logic [32:0]    fetched_sum, flushed_sum;

    // On redirect: held entries not leaving now, plus the response arriving now.
    always_comb begin
        flushed_inc = '0;
        if (flush)                   flushed_inc = {1'b0, count} - (CNT_W+1)'(pop) + (CNT_W+1)'(inflight_q);
        else if (inflight_q && drop) flushed_inc = (CNT_W+1)'(1);
    end

    assign fetched_sum = {1'b0, stat_fetched_q} + 33'(push & !flush);
    assign flushed_sum = {1'b0, stat_flushed_q} + 33'(flushed_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_fetched_q <= '0;
            stat_flushed_q <= '0;
        end else begin
            stat_fetched_q <= fetched_sum[32] ? '1 : fetched_sum[31:0];
            stat_flushed_q <= flushed_sum[32] ? '1 : flushed_sum[31:0];
        end
    end

    assign stat_fetched_o = stat_fetched_q;
    assign stat_flushed_o = stat_flushed_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit; imem model returns address as data.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.PC_W(32)) bus   ();
    instruction_fetch_unit_if #(.PC_W(32)) bus_w ();

    instruction_fetch_unit #(
        .PC_W(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    instruction_fetch_unit #(
        .PC_W(32), .RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)
    ) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    // Synchronous imem: data one cycle after the request; garbage otherwise.
    always @(posedge clk) begin
        bus.imem_rdata   <= bus.imem_req   ? bus.imem_addr   : 32'hBAD0_BAD0;
        bus_w.imem_rdata <= bus_w.imem_req ? bus_w.imem_addr : 32'hBAD0_BAD0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle_inputs();
        bus.inst_ready       = 1'b1;
        bus.redirect_valid   = 1'b0;
        bus.redirect_pc      = '0;
        bus_w.inst_ready     = 1'b1;
        bus_w.redirect_valid = 1'b0;
        bus_w.redirect_pc    = '0;
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        hold_reset();
        #1;
        n_checks++;
        if (bus.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %b want 0", bus.imem_req);
        end
        n_checks++;
        if (bus.inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", bus.inst_valid);
        end
        n_checks++;
        if ({bus.inst, bus.inst_pc, bus.inst_pc4, bus.imem_addr} !== 128'h0) begin
            n_fail++; $display("FAIL reset_data: inst %h pc %h pc4 %h addr %h want all 0",
                               bus.inst, bus.inst_pc, bus.inst_pc4, bus.imem_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        hold_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) rst = 1'b0;
            #1;
            if (c == 0) begin
                n_checks++;
                if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
                    n_fail++; $display("FAIL stream_first_req: req %b addr %h want 1 00000000",
                                       bus.imem_req, bus.imem_addr);
                end
            end
            n_checks++;
            if (bus.inst_valid !== (c >= 2)) begin
                n_fail++; $display("FAIL stream_valid c%0d: got %b want %b", c, bus.inst_valid, c >= 2);
            end
            if (c >= 2) begin
                exp = 32'((c - 2) * 4);
                n_checks++;
                if ({bus.inst, bus.inst_pc, bus.inst_pc4} !== {exp, exp, exp + 32'd4}) begin
                    n_fail++; $display("FAIL stream_word c%0d: inst %h pc %h pc4 %h want %h %h %h",
                                       c, bus.inst, bus.inst_pc, bus.inst_pc4, exp, exp, exp + 32'd4);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp = 32'h0;
        hold_reset();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) rst = 1'b0;
            bus.inst_ready = !(c >= 3 && c <= 7);
            #1;
            if (c >= 2) begin
                n_checks++;
                if ({bus.inst_valid, bus.inst} !== {1'b1, exp}) begin
                    n_fail++; $display("FAIL bp_word c%0d: valid %b inst %h want 1 %h",
                                       c, bus.inst_valid, bus.inst, exp);
                end
                if (bus.inst_ready) exp = exp + 32'd4;
            end
            if (c >= 3 && c <= 7) begin
                n_checks++;
                if (bus.imem_req !== 1'b0) begin
                    n_fail++; $display("FAIL bp_stall_req c%0d: got %b want 0", c, bus.imem_req);
                end
            end
            if (c == 8) begin
                n_checks++;
                if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'hC}) begin
                    n_fail++; $display("FAIL bp_resume_req: req %b addr %h want 1 0000000c",
                                       bus.imem_req, bus.imem_addr);
                end
            end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] exp = 32'h0;
        hold_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) rst = 1'b0;
            bus.redirect_valid = (c == 3);
            bus.redirect_pc    = 32'h0000_0100;
            #1;
            if (c == 3) begin
                n_checks++;
                if (bus.imem_req !== 1'b0) begin
                    n_fail++; $display("FAIL redir_req_blocked: got %b want 0", bus.imem_req);
                end
            end
            if (c == 4) begin
                n_checks++;
                if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h100}) begin
                    n_fail++; $display("FAIL redir_new_req: req %b addr %h want 1 00000100",
                                       bus.imem_req, bus.imem_addr);
                end
            end
            if (c == 4 || c == 5) begin
                n_checks++;
                if (bus.inst_valid !== 1'b0) begin
                    n_fail++; $display("FAIL redir_gap c%0d: valid %b inst %h want 0",
                                       c, bus.inst_valid, bus.inst);
                end
            end else if (c >= 2) begin
                n_checks++;
                if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, exp, exp}) begin
                    n_fail++; $display("FAIL redir_word c%0d: valid %b inst %h pc %h want 1 %h %h",
                                       c, bus.inst_valid, bus.inst, bus.inst_pc, exp, exp);
                end
                exp = (c == 3) ? 32'h100 : exp + 32'd4;
            end
        end
        bus.redirect_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        hold_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) rst = 1'b0;
            bus.redirect_valid = (c == 3 || c == 4);
            bus.redirect_pc    = (c == 3) ? 32'h0000_0300 : 32'h0000_0203;
            #1;
            if (c == 3 || c == 4) begin
                n_checks++;
                if (bus.imem_req !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_req_blocked c%0d: got %b want 0", c, bus.imem_req);
                end
            end
            if (c == 5) begin
                n_checks++;
                if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h200}) begin
                    n_fail++; $display("FAIL b2b_aligned_req: req %b addr %h want 1 00000200",
                                       bus.imem_req, bus.imem_addr);
                end
            end
            if (c >= 4 && c <= 6) begin
                n_checks++;
                if (bus.inst_valid !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_gap c%0d: valid %b pc %h want 0", c, bus.inst_valid, bus.inst_pc);
                end
            end
            if (c == 7) begin
                n_checks++;
                if ({bus.inst_valid, bus.inst, bus.inst_pc, bus.inst_pc4} !== {1'b1, 32'h200, 32'h200, 32'h204}) begin
                    n_fail++; $display("FAIL b2b_first: valid %b inst %h pc %h pc4 %h want 1 200 200 204",
                                       bus.inst_valid, bus.inst, bus.inst_pc, bus.inst_pc4);
                end
            end
            if (c == 8) begin
                n_checks++;
                if (bus.inst_pc !== 32'h204) begin
                    n_fail++; $display("FAIL b2b_second: pc %h want 00000204", bus.inst_pc);
                end
            end
        end
        bus.redirect_valid = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        hold_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) rst = 1'b0;
            #1;
            if (c == 0) begin
                n_checks++;
                if ({bus_w.imem_req, bus_w.imem_addr} !== {1'b1, 32'hFFFF_FFF8}) begin
                    n_fail++; $display("FAIL wrap_first_req: req %b addr %h want 1 fffffff8",
                                       bus_w.imem_req, bus_w.imem_addr);
                end
            end
            if (c >= 2) begin
                exp = 32'hFFFF_FFF8 + 32'((c - 2) * 4);
                n_checks++;
                if ({bus_w.inst_valid, bus_w.inst_pc, bus_w.inst_pc4} !== {1'b1, exp, exp + 32'd4}) begin
                    n_fail++; $display("FAIL wrap_pc c%0d: valid %b pc %h pc4 %h want 1 %h %h",
                                       c, bus_w.inst_valid, bus_w.inst_pc, bus_w.inst_pc4, exp, exp + 32'd4);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        hold_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) rst = 1'b0;
            #1;
        end
        n_checks++;
        if (bus.imem_req !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pending: req %b want 1", bus.imem_req);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.imem_req, bus.inst_valid, bus.imem_addr, bus.inst, bus.inst_pc, bus.inst_pc4} !== 130'h0) begin
            n_fail++; $display("FAIL midrst_outputs: req %b valid %b addr %h inst %h pc %h pc4 %h want all 0",
                               bus.imem_req, bus.inst_valid, bus.imem_addr, bus.inst, bus.inst_pc, bus.inst_pc4);
        end
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) rst = 1'b0;
            #1;
            if (c == 0) begin
                n_checks++;
                if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
                    n_fail++; $display("FAIL midrst_restart_req: req %b addr %h want 1 00000000",
                                       bus.imem_req, bus.imem_addr);
                end
            end
            if (c == 1) begin
                n_checks++;
                if (bus.inst_valid !== 1'b0) begin
                    n_fail++; $display("FAIL midrst_no_stale: valid %b inst %h want 0", bus.inst_valid, bus.inst);
                end
            end
            if (c == 2) begin
                n_checks++;
                if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, 32'h0, 32'h0}) begin
                    n_fail++; $display("FAIL midrst_first_word: valid %b inst %h pc %h want 1 0 0",
                                       bus.inst_valid, bus.inst, bus.inst_pc);
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
